button_bank: RTL
================

# button_bank

Parametrised bank of debounced push-button channels for board-level user input. Each channel synchronises a raw, bounce-prone pin, debounces it with a stability counter, and produces a clean level, one-cycle press/release strobes and a press-toggled latch. An optional long-press detector can be compiled in. The block sits directly behind the board button pins and feeds LED and control logic.

## Interface
- `N_CH`, default 2: number of button channels, at least 1.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a change, at least 1.
- `LONG_CYCLES`, default 50000000: held cycles after a press that fire `long_press`, at least 1.
- `ACTIVE_LOW`, default 1: 1 means a pin reads 0 when pressed; 0 means a pin reads 1 when pressed.
- `TOGGLE_INIT`, default 0: reset value of every `toggle` bit.

- `clk`, input, 1 bit: the only clock; all logic is on its rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `btn_raw`, input, `N_CH` bits: raw button pins, asynchronous to `clk`.
- `level`, output, `N_CH` bits: debounced state, 1 = pressed.
- `press`, output, `N_CH` bits: one-cycle strobe when `level` goes 0→1.
- `release`, output, `N_CH` bits: one-cycle strobe when `level` goes 1→0.
- `toggle`, output, `N_CH` bits: flips on each `press`.
- `all_pressed`, output, 1 bit: AND of all `level` bits.
- `long_press`, output, `N_CH` bits: one-cycle strobe; present only with `BUTTON_BANK_LONG_EN`.

## Operation
- **Polarity:** raw pins are normalised to pressed = 1 when `ACTIVE_LOW` = 1, by inverting them before synchronisation.
- **Synchronisation:** each channel has a 2-flop synchroniser. The synchronised sample is called `s`.
- **Debounce counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s` equals `level`: `cnt` is cleared to 0.
  - Else if `cnt` equals `DEBOUNCE_CYCLES-1`: `level` takes the value of `s` and `cnt` is cleared.
  - Else: `cnt` increments by 1.
- **Glitches:** a single cycle in which `s` equals `level` restarts the count. Bounces shorter than `DEBOUNCE_CYCLES` never reach `level`.
- **Strobes:** `press` and `release` are registered. They are high on exactly the cycle in which `level` updates, never both high together, and never back-to-back on one channel.
- **Toggle:** `toggle[i]` inverts on the same edge that asserts `press[i]`. A release does not change it.
- **Chord:** `all_pressed` is combinational from the `level` registers. It carries no extra debounce.
- **Independence:** channels are fully independent. Simultaneous events on several channels all take effect in the same cycle.
- **Reset values:** while `rst` is high at a clock edge, every output and internal register takes its reset value:
  - synchroniser flops, `level`, `press`, `release`, `long_press`, `all_pressed`, `cnt` and long counters: 0 (synchroniser flops hold the normalised released value);
  - `toggle`: `TOGGLE_INIT`.
- **Reset mid-operation:** a button held through reset is treated as a new press after reset deasserts. It asserts `press` once debounce completes.

## Timing
- **Press or release latency:** `level` and its strobe change on the (`DEBOUNCE_CYCLES`+2)-th rising edge counting from the first edge that samples the new raw value, provided the raw value holds throughout.
- **Toggle latency:** `toggle` updates on the same edge as `press`.
- **`all_pressed` latency:** it follows `level` with zero added latency.
- **Long-press latency:** `long_press` fires `LONG_CYCLES` edges after the edge that asserted `press`, if `level` stays 1 throughout.
- **Clocking:** there are no multicycle paths and no handshakes. The strobes are single-cycle pulses meant for consumers in the `clk` domain.

## Configuration
- Macro: `BUTTON_BANK_LONG_EN`.
- **Defined:**
  - Each channel gets a hold counter, width `$clog2(LONG_CYCLES+1)`. It is cleared while `level` is 0 and increments while `level` is 1, saturating at `LONG_CYCLES`.
  - `long_press[i]` pulses for one cycle when the counter reaches `LONG_CYCLES`. It fires once per press, with no auto-repeat.
  - A release before that point cancels it.
- **Undefined:** the `long_press` port, the hold counters and `LONG_CYCLES` usage are removed entirely. All other behaviour is identical.

## Structure
- **Package `button_pkg`:**
  - a function `cnt_width(n)` returning `$clog2(n+1)`;
  - the polarity constants `BTN_ACTIVE_LOW` = 1 and `BTN_ACTIVE_HIGH` = 0.
- **Sub-module `button_debounce`:** one channel, containing the synchroniser, debounce counter, `level`, strobes, toggle and optional long-press counter.
- **Top level `button_bank`:** instantiates `button_debounce` `N_CH` times in a generate loop and forms `all_pressed`.

## Test plan
Bench parameters: `N_CH`=2, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=16, `ACTIVE_LOW`=1, with `BUTTON_BANK_LONG_EN` defined.

- **Reset:** drive `rst` high for 3 cycles with `btn_raw`=2'b11 → all outputs are 0 and `toggle`=2'b00.
- **Clean press:** drive `btn_raw[0]` to 0 and hold → `level[0]`=1 and a one-cycle `press[0]` on edge 6; `toggle[0]`=1 on the same edge.
- **Bounce:**
  - `btn_raw[0]` pattern 0,0,0,1,0,0,1, then steady 0 → only one `press[0]`, arriving 6 edges after the last 1→0 transition;
  - a 3-cycle low pulse → no `press`.
- **Long press:** hold ch0 pressed for 30 cycles → one `long_press[0]` pulse 16 edges after `press[0]`, and no second pulse.
- **Release before long:** release ch0 after 10 held cycles → no `long_press`, and `release[0]` 6 edges after the release edge.
- **Chord and reset mid-hold:**
  - press both channels in the same cycle → `press`=2'b11 in one cycle, then `all_pressed`=1;
  - assert `rst` while both are held → all outputs clear; after `rst` deasserts, `press`=2'b11 again after 6 edges.

Source files
------------

// File: rtl/button_pkg.sv
// Shared polarity constants and the counter-sizing helper for the button bank.
package button_pkg;

   localparam int BTN_ACTIVE_LOW  = 1;
   localparam int BTN_ACTIVE_HIGH = 0;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, stability-counter debounce, strobes and toggle.
// Optional hold counter and long_press strobe when BUTTON_BANK_LONG_EN is defined.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int ACTIVE_LOW      = BTN_ACTIVE_LOW,
   parameter bit TOGGLE_INIT     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic release_strb,
   output logic toggle
`ifdef BUTTON_BANK_LONG_EN
   ,
   output logic long_press
`endif
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          pin_norm_s;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          toggle_q, toggle_d;

   // Normalise the pin so that 1 always means pressed before it enters the synchroniser.
   always_comb begin
      if (ACTIVE_LOW == BTN_ACTIVE_LOW) begin
         pin_norm_s = ~btn_raw;
      end else begin
         pin_norm_s = btn_raw;
      end
   end

   // Debounce: any cycle where the sample agrees with level restarts the stability count.
   always_comb begin
      sync1_d   = pin_norm_s;
      sync2_d   = sync1_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      toggle_d  = toggle_q;
      if (sync2_q == level_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         cnt_d     = {CW{1'b0}};
         level_d   = sync2_q;
         press_d   = sync2_q;
         release_d = ~sync2_q;
         toggle_d  = toggle_q ^ sync2_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= {CW{1'b0}};
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         toggle_q  <= TOGGLE_INIT;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         toggle_q  <= toggle_d;
      end
   end

   assign level        = level_q;
   assign press        = press_q;
   assign release_strb = release_q;
   assign toggle       = toggle_q;

`ifdef BUTTON_BANK_LONG_EN
   localparam int            HW        = cnt_width(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Hold counter saturates at LONG_CYCLES, so the strobe fires once per press.
   always_comb begin
      hold_d = {HW{1'b0}};
      long_d = 1'b0;
      if (level_q) begin
         if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
         end else begin
            hold_d = hold_q;
         end
         long_d = (hold_q == HOLD_FIRE);
      end else begin
         hold_d = {HW{1'b0}};
         long_d = 1'b0;
      end
   end

   // Long-press registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= {HW{1'b0}};
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`endif

endmodule

// File: rtl/button_bank.sv
// Bank of N_CH independent debounced buttons plus a combinational all-pressed chord.
// "release" is a reserved word, so that strobe is named release_strb. Long press: BUTTON_BANK_LONG_EN.
module button_bank
   import button_pkg::*;
#(
   parameter int N_CH            = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int ACTIVE_LOW      = BTN_ACTIVE_LOW,
   parameter bit TOGGLE_INIT     = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_strb,
   output logic [N_CH-1:0] toggle,
   output logic            all_pressed
`ifdef BUTTON_BANK_LONG_EN
   ,
   output logic [N_CH-1:0] long_press
`endif
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .TOGGLE_INIT     (TOGGLE_INIT)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .btn_raw      (btn_raw[i]),
         .level        (level[i]),
         .press        (press[i]),
         .release_strb (release_strb[i]),
         .toggle       (toggle[i])
`ifdef BUTTON_BANK_LONG_EN
         ,
         .long_press   (long_press[i])
`endif
      );
   end

   assign all_pressed = &level;

endmodule
